// File: rtl/shift_arbiter_pkg.sv
// Types and helpers local to the shift arbiter: output-register states,
// the request payload and the round-robin pointer advance.
package shift_arbiter_pkg;
  import shift_pkg::*;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]          alufn;
    logic [SH_BITS-1:0]  a;
    logic [SH_AMT_W-1:0] b;
  } sh_req_t;

  // Pointer moves to the requester after the winner, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : shift_arbiter_pkg

// File: rtl/shift_pkg.sv
// Shared shift-datapath constants: op encoding and operand/amount widths.
package shift_pkg;

  localparam int unsigned SH_BITS  = 16;
  localparam int unsigned SH_AMT_W = 4;

  localparam logic [1:0] SHOP_SHL = 2'b00;
  localparam logic [1:0] SHOP_SHR = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b11;

endpackage : shift_pkg

// File: rtl/shift_arbiter_if.sv
// Request/response bus between the requesters/consumer and the shift arbiter.
interface shift_arbiter_if
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned BITS = SH_BITS
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [2*NREQ-1:0]        req_alufn;
  logic [BITS*NREQ-1:0]     req_a;
  logic [SH_AMT_W*NREQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [BITS-1:0]          rsp_data;

  // Requesters plus result consumer.
  modport master (
    output req_valid, req_alufn, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_alufn, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface : shift_arbiter_if

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps;
// the first asserted request wins. Grant is one-hot and gated by en_i,
// the index is reported regardless so the datapath can pre-select.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  idx_c
);

  logic found_c;

  // Rotating priority search from the pointer.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      int j;
      j = (int'(ptr_i) + i) % int'(NREQ);
      if (!found_c && req_i[j]) begin
        found_c  = 1'b1;
        idx_c    = IDW'(j);
        gnt_c[j] = en_i;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/shifter_16.sv
// 16-bit combinational log shifter, four stages of 1/2/4/8.
// alufn: 00 SHL, 01 SHR, 11 SRA, 10 SHL.
module shifter_16
  import shift_pkg::*;
(
  input  logic [1:0]          alufn_i,
  input  logic [SH_BITS-1:0]  a_i,
  input  logic [SH_AMT_W-1:0] b_i,
  output logic [SH_BITS-1:0]  y_c
);

  logic [SH_BITS-1:0] stg [SH_AMT_W+1];

  // Each stage conditionally shifts by 2**k according to bit k of the amount.
  always_comb begin
    stg[0] = a_i;
    for (int k = 0; k < int'(SH_AMT_W); k++) begin
      if (b_i[k]) begin
        case (alufn_i)
          SHOP_SHR: stg[k+1] = stg[k] >> (1 << k);
          SHOP_SRA: stg[k+1] = SH_BITS'($signed(stg[k]) >>> (1 << k));
          default:  stg[k+1] = stg[k] << (1 << k);
        endcase
      end else begin
        stg[k+1] = stg[k];
      end
    end
    y_c = stg[SH_AMT_W];
  end

endmodule : shifter_16

// File: rtl/shift_arbiter.sv
// Shares one shifter_16 between NREQ requesters with round-robin arbitration
// and a single registered, ID-tagged result stage (1 result/cycle).
// Optional per-requester grant counters: define SHIFT_ARB_STATS_EN.
module shift_arbiter
  import shift_pkg::*;
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned BITS = SH_BITS
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SHIFT_ARB_STATS_EN
  input  logic               stat_clr,
  output logic [16*NREQ-1:0] stat_grants,
`endif
  shift_arbiter_if.slave     bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;

  logic            can_accept_c;
  logic            arb_en_c;
  logic            xfer_c;
  logic [NREQ-1:0] gnt_c;
  logic [IDW-1:0]  win_idx_c;
  sh_req_t         win_pl_c;
  logic [BITS-1:0] shift_y_c;

  // Result slot can take new data when empty or being drained this cycle.
  assign can_accept_c = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign arb_en_c     = can_accept_c && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en_c),
    .gnt_c (gnt_c),
    .idx_c (win_idx_c)
  );

  assign xfer_c        = |gnt_c;
  assign bus.req_ready = gnt_c;

  // Steer the winning requester's payload onto the shared shifter.
  always_comb begin
    win_pl_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == win_idx_c) begin
        win_pl_c.alufn = bus.req_alufn[2*i +: 2];
        win_pl_c.a     = bus.req_a[BITS*i +: BITS];
        win_pl_c.b     = bus.req_b[SH_AMT_W*i +: SH_AMT_W];
      end
    end
  end

  shifter_16 u_shf (
    .alufn_i (win_pl_c.alufn),
    .a_i     (win_pl_c.a),
    .b_i     (win_pl_c.b),
    .y_c     (shift_y_c)
  );

  // Output-slot state, result capture and pointer advance.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_EMPTY: if (xfer_c) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !xfer_c) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (xfer_c) begin
      ptr_d      = IDW'(rr_next(32'(win_idx_c), NREQ));
      rsp_id_d   = win_idx_c;
      rsp_data_d = shift_y_c;
    end
  end

  // State and result registers; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];

  // Saturating per-requester grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < int'(NREQ); i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (gnt_c[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the stats port.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < int'(NREQ); i++) stat_grants[16*i +: 16] = grant_cnt_q[i];
  end
`endif

endmodule : shift_arbiter

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one `shifter_16` instance between NREQ requesters (ALU issue port, branch/address unit, debug/test port).
- Uses round-robin arbitration and a valid/ready handshake on every port.
- Issues one registered result per cycle, tagged with the winning requester ID.
- Sits between the requesters and the shared shift datapath; shifter encoding and semantics are unchanged.

Parameters:
- NREQ, 2, number of requesters, legal range 2..4.
- BITS, 16, operand width; fixed at 16 because `shifter_16` is 4-stage.
- IDW, $clog2(NREQ), requester ID width, derived.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; transfer happens when valid and ready are both high.
- req_alufn  in  2*NREQ  per-requester shift op: 00 SHL, 01 SHR, 11 SRA, 10 SHL.
- req_a  in  BITS*NREQ  per-requester operand.
- req_b  in  4*NREQ  per-requester shift amount, 0..15.
- rsp_valid  out  1  result register holds data.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  BITS  shifted result.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready is all-zero during the reset cycle.
  - A reset mid-operation discards the pending result without delivering it.
- Output register states: EMPTY or FULL.
  - can_accept = EMPTY or (FULL and rsp_ready).
- Arbitration is combinational each cycle.
  - Search starts at the pointer and wraps modulo NREQ; the first requester with valid=1 wins.
  - req_ready is one-hot at the winner when can_accept=1; otherwise it is zero.
  - A non-winning requester must hold its valid and payload stable until it is accepted.
- On a transfer:
  - The winner's operands drive the shared shifter combinationally.
  - rsp_data, rsp_id and rsp_valid are registered at the next edge, giving 1-cycle latency.
  - The pointer becomes (winner+1) mod NREQ.
- If there is no transfer, the pointer holds.
- State transitions:
  - EMPTY → FULL on a transfer.
  - FULL with rsp_ready=1 and a new transfer → stays FULL with the new data, giving 1 result/cycle throughput.
  - FULL with rsp_ready=1 and no transfer → EMPTY.
  - FULL with rsp_ready=0 → holds; rsp_data and rsp_id are stable and all req_ready are low.
- Requesters with req_valid=0 are never granted.
- With a single active requester, that requester is granted every cycle.
- Shift semantics equal `shifter_16`:
  - SRA pads with a[15], SHR pads with 0.
  - b=0 passes a through unchanged.
  - alufn=10 behaves as SHL.

Optional Feature:
- Macro SHIFT_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants, width 16*NREQ: per-requester grant counters.
  - Each counter increments on every transfer from that requester and saturates at 0xFFFF.
  - Counters clear on rst.
  - Adds input stat_clr, width 1: synchronous clear of all counters. If stat_clr and a grant occur in the same cycle, the counter is 0 afterwards.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package shift_pkg:
  - Op encoding constants SHOP_SHL=2'b00, SHOP_SHR=2'b01, SHOP_SRA=2'b11.
  - Constant SH_BITS=16.
  - Constant SH_AMT_W=4.
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant plus encoded index.
- The top level instantiates rr_arbiter and `shifter_16`, and holds the output register and pointer.

Test Plan:
- Reset check: assert rst for 2 cycles with all req_valid=1 → req_ready=0 and rsp_valid=0 during reset; first grant goes to requester 0.
- Single request: requester 1 sends alufn=11, a=0x8000, b=3 → one cycle later rsp_valid=1, rsp_id=1, rsp_data=0xF000.
- Fairness: both requesters held valid continuously with rsp_ready=1 → grants alternate 0,1,0,1; one result every cycle.
- Backpressure: rsp_ready=0 while FULL with SHL a=0x0001, b=15 → rsp_data holds 0x8000 and req_ready stays 0 for 5 cycles; rsp_ready=1 then drains and accepts the next request in the same cycle.
- Boundary ops:
  - SHR a=0xFFFF, b=15 → 0x0001.
  - b=0 with any op → a unchanged.
  - alufn=10, a=0x00F0, b=4 → 0x0F00.
- With SHIFT_ARB_STATS_EN:
  - 3 grants to requester 0 → stat_grants[0]=3.
  - stat_clr asserted together with a grant → counter reads 0.
  - Counter preset to 0xFFFF, then granted → stays 0xFFFF.
